demux_1_to_16_reg: RTL and testbench

Registered 1-to-16 demultiplexer/deserializer: the write-side counterpart of the 16-to-1 select path. It steers a 1-bit input into one of 16 lane slots. The slot is chosen either by an explicit 4-bit select or by an internal auto-incrementing slot counter. Once every slot has been written, it publishes the assembled 16-bit word with a one-cycle valid pulse. Lane i of the output maps to select value i, so feeding `out` back through the 16-to-1 mux with the same S returns the bit written to that slot.

---
 rtl/demux_1_to_16_reg.sv | 103 ++++++++++
 tb/tb_demux_1_to_16_reg.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_to_16_reg.sv
// ---------------------------------------------------------------------------
// demux_1_to_16_reg
//
// Registered 1-to-16 demultiplexer / deserializer. A 1-bit input is steered
// into one of 16 lane slots. The slot comes from the explicit select S
// (auto=0) or from an internal auto-incrementing counter (auto=1). When every
// slot of the current frame has been written at least once, the assembled
// word is published on out together with a one-cycle out_valid pulse.
//
// Lane i of out holds the bit written with target slot i. Passing out back
// through a 16-to-1 mux with the same S returns that bit.
//
// All outputs come straight from registers. No input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module demux_1_to_16_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   input  logic [3:0]  S,
   input  logic        wr_en,
   input  logic        auto,
   input  logic        clear,
   output logic [15:0] out,
   output logic        out_valid,
   output logic [3:0]  slot,
   output logic [15:0] pending
);

   localparam logic [15:0] ALL_SLOTS = 16'hFFFF;

   // Frame state
   logic [15:0] r_shadow;     // bits of the frame being assembled
   logic [15:0] r_pending;    // slots already written in this frame
   logic [3:0]  r_slot;       // auto-mode slot counter

   // Published word
   logic [15:0] r_out;
   logic        r_out_valid;

   // Write-path decode
   logic [3:0]  w_target;     // slot addressed by this write
   logic [15:0] w_onehot;     // onehot(w_target)
   logic [15:0] w_pending_nx; // written mask once this write is counted
   logic [15:0] w_shadow_nx;  // shadow with the target bit replaced by din
   logic        w_write;      // write accepted this cycle (clear wins)
   logic        w_complete;   // this write finishes the frame

   // Decode the target slot and the frame state a write would produce.
   // Rewriting a slot leaves the mask unchanged, so it can never be the
   // write that completes a frame.
   always_comb begin
      w_target     = auto ? r_slot : S;
      w_onehot     = 16'd1 << w_target;
      w_pending_nx = r_pending | w_onehot;
      w_shadow_nx  = (r_shadow & ~w_onehot) | (din ? w_onehot : 16'd0);
      w_write      = wr_en & ~clear;
      w_complete   = w_write & (w_pending_nx == ALL_SLOTS);
   end

   // Frame assembly, completion and abort. clear has priority and drops
   // any write sampled on the same edge. out only changes on completion or
   // reset.
   // NOTE: every register here, the 16-bit shadow included, is cleared by
   // the async reset so a reset discards the partial frame completely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow    <= '0;
         r_pending   <= '0;
         r_slot      <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking default. A later assignment in this block
         // overrides it, so out_valid only stays high on a completion edge.
         r_out_valid <= 1'b0;

         if (clear) begin
            r_shadow  <= '0;
            r_pending <= '0;
            r_slot    <= '0;
         end else if (w_complete) begin
            r_out       <= w_shadow_nx;
            r_out_valid <= 1'b1;
            r_shadow    <= '0;
            r_pending   <= '0;
            r_slot      <= '0;
         end else if (w_write) begin
            r_shadow  <= w_shadow_nx;
            r_pending <= w_pending_nx;
            if (auto) begin
               r_slot <= r_slot + 4'd1;   // wraps 15 -> 0 naturally
            end
         end
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign slot      = r_slot;
   assign pending   = r_pending;

endmodule

// File: tb/tb_demux_1_to_16_reg.sv
// ---------------------------------------------------------------------------
// tb_demux_1_to_16_reg
//
// Directed bench for demux_1_to_16_reg. Each scenario task drives inputs
// right after a rising edge and samples outputs 1 ns after the rising edge.
// Expected values are fixed constants worked out by hand.
// ---------------------------------------------------------------------------
module tb_demux_1_to_16_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        din;
   logic [3:0]  S;
   logic        wr_en;
   logic        auto;
   logic        clear;
   logic [15:0] out;
   logic        out_valid;
   logic [3:0]  slot;
   logic [15:0] pending;

   int errors = 0;
   int checks = 0;

   demux_1_to_16_reg dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .S         (S),
      .wr_en     (wr_en),
      .auto      (auto),
      .clear     (clear),
      .out       (out),
      .out_valid (out_valid),
      .slot      (slot),
      .pending   (pending)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Hard time limit so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one clock edge and settle 1 ns past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Async reset mid-frame, then idle with no pulse
   task automatic test_reset();
      int pulses;
      rst = 1'b1; din = 1'b0; S = 4'd0; wr_en = 1'b0; auto = 1'b0; clear = 1'b0;
      tick(); tick();
      checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", out); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (slot !== 4'd0) begin errors++; $display("FAIL reset_slot: got %0d expected 0", slot); end
      checks++; if (pending !== 16'h0000) begin errors++; $display("FAIL reset_pending: got %h expected 0000", pending); end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         auto = 1'b1; wr_en = 1'b1; din = 1'b1;
         tick();
      end
      checks++; if (pending !== 16'h001F) begin errors++; $display("FAIL five_writes_pending: got %h expected 001f", pending); end
      checks++; if (slot !== 4'd5) begin errors++; $display("FAIL five_writes_slot: got %0d expected 5", slot); end
      wr_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (out !== 16'h0000) begin errors++; $display("FAIL midframe_reset_out: got %h expected 0000", out); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midframe_reset_valid: got %b expected 0", out_valid); end
      checks++; if (slot !== 4'd0) begin errors++; $display("FAIL midframe_reset_slot: got %0d expected 0", slot); end
      checks++; if (pending !== 16'h0000) begin errors++; $display("FAIL midframe_reset_pending: got %h expected 0000", pending); end
      #1 rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", pulses); end
      checks++; if (pending !== 16'h0000) begin errors++; $display("FAIL idle_pending: got %h expected 0000", pending); end
   endtask

   // 16 auto writes of A5C3, LSB first; leaves wr_en high for back-to-back
   task automatic test_auto_fill();
      logic [15:0] word;
      word = 16'hA5C3;
      for (int i = 0; i < 16; i++) begin
         auto = 1'b1; wr_en = 1'b1; clear = 1'b0; din = word[i];
         checks++; if (slot !== 4'(i)) begin errors++; $display("FAIL auto_slot_%0d: got %0d expected %0d", i, slot, i); end
         tick();
         if (i < 15) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL auto_early_valid_%0d: got %b expected 0", i, out_valid); end
         end
      end
      checks++; if (out !== 16'hA5C3) begin errors++; $display("FAIL auto_out: got %h expected a5c3", out); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL auto_valid: got %b expected 1", out_valid); end
      checks++; if (slot !== 4'd0) begin errors++; $display("FAIL auto_slot_after: got %0d expected 0", slot); end
      checks++; if (pending !== 16'h0000) begin errors++; $display("FAIL auto_pending_after: got %h expected 0000", pending); end
   endtask

   // Second frame 1234 straight after the first; pulse exactly 16 edges later
   task automatic test_back_to_back();
      logic [15:0] word;
      word = 16'h1234;
      for (int i = 0; i < 16; i++) begin
         din = word[i];
         tick();
         if (i == 0) begin
            checks++; if (out !== 16'hA5C3) begin errors++; $display("FAIL b2b_out_hold: got %h expected a5c3", out); end
         end
         checks++;
         if (out_valid !== (i == 15)) begin
            errors++; $display("FAIL b2b_valid_%0d: got %b expected %b", i, out_valid, (i == 15));
         end
      end
      checks++; if (out !== 16'h1234) begin errors++; $display("FAIL b2b_out: got %h expected 1234", out); end
      checks++; if (slot !== 4'd0) begin errors++; $display("FAIL b2b_slot: got %0d expected 0", slot); end
      wr_en = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b expected 0", out_valid); end
      checks++; if (out !== 16'h1234) begin errors++; $display("FAIL b2b_out_idle: got %h expected 1234", out); end
   endtask

   // Addressed fill in reverse order with a rewrite of slot 3, then a frame
   // where slot 3 is the last distinct write
   task automatic test_addressed_rewrite();
      logic [15:0] word;
      auto = 1'b0; wr_en = 1'b1; clear = 1'b0;
      for (int s = 15; s >= 4; s--) begin
         S = 4'(s); din = 1'b1;
         tick();
      end
      S = 4'd3; din = 1'b0;
      tick();
      checks++; if (pending !== 16'hFFF8) begin errors++; $display("FAIL addr_pending_first3: got %h expected fff8", pending); end
      S = 4'd3; din = 1'b1;
      tick();
      checks++; if (pending !== 16'hFFF8) begin errors++; $display("FAIL addr_pending_rewrite3: got %h expected fff8", pending); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addr_rewrite_valid: got %b expected 0", out_valid); end
      for (int s = 2; s >= 1; s--) begin
         S = 4'(s); din = 1'b1;
         tick();
      end
      checks++; if (pending !== 16'hFFFE) begin errors++; $display("FAIL addr_pending_before0: got %h expected fffe", pending); end
      checks++; if (slot !== 4'd0) begin errors++; $display("FAIL addr_slot_hold: got %0d expected 0", slot); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addr_valid_before0: got %b expected 0", out_valid); end
      S = 4'd0; din = 1'b1;
      tick();
      checks++; if (out !== 16'hFFFF) begin errors++; $display("FAIL addr_out: got %h expected ffff", out); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addr_valid: got %b expected 1", out_valid); end
      checks++; if (pending !== 16'h0000) begin errors++; $display("FAIL addr_pending_after: got %h expected 0000", pending); end

      word = 16'h5A5A;
      for (int s = 15; s >= 0; s--) begin
         if (s != 3) begin
            S = 4'(s); din = word[s];
            tick();
         end
      end
      checks++; if (pending !== 16'hFFF7) begin errors++; $display("FAIL addr2_pending_before3: got %h expected fff7", pending); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addr2_valid_before3: got %b expected 0", out_valid); end
      S = 4'd3; din = word[3];
      tick();
      checks++; if (out !== 16'h5A5A) begin errors++; $display("FAIL addr2_out: got %h expected 5a5a", out); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addr2_valid: got %b expected 1", out_valid); end
      wr_en = 1'b0;
      tick();
   endtask

   // clear beats a simultaneous write; a fresh frame afterwards completes
   task automatic test_clear_priority();
      logic [15:0] word;
      int pulses;
      auto = 1'b1; wr_en = 1'b1; clear = 1'b0;
      for (int i = 0; i < 10; i++) begin
         din = i[0];
         tick();
      end
      checks++; if (slot !== 4'd10) begin errors++; $display("FAIL clr_slot_before: got %0d expected 10", slot); end
      checks++; if (pending !== 16'h03FF) begin errors++; $display("FAIL clr_pending_before: got %h expected 03ff", pending); end
      clear = 1'b1; din = 1'b1;
      tick();
      clear = 1'b0;
      checks++; if (pending !== 16'h0000) begin errors++; $display("FAIL clr_pending: got %h expected 0000", pending); end
      checks++; if (slot !== 4'd0) begin errors++; $display("FAIL clr_slot: got %0d expected 0", slot); end
      checks++; if (out !== 16'h5A5A) begin errors++; $display("FAIL clr_out_hold: got %h expected 5a5a", out); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b expected 0", out_valid); end
      word = 16'h0F0F;
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         din = word[i];
         tick();
         if (out_valid) pulses++;
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL clr_fresh_pulses: got %0d expected 1", pulses); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_fresh_valid: got %b expected 1", out_valid); end
      checks++; if (out !== 16'h0F0F) begin errors++; $display("FAIL clr_fresh_out: got %h expected 0f0f", out); end
      wr_en = 1'b0;
      tick();
   endtask

   // 8 auto writes of 1, then addressed writes of 0 to slots 8..15
   task automatic test_mixed_mode();
      auto = 1'b1; wr_en = 1'b1; clear = 1'b0; din = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      checks++; if (slot !== 4'd8) begin errors++; $display("FAIL mixed_slot_auto: got %0d expected 8", slot); end
      checks++; if (pending !== 16'h00FF) begin errors++; $display("FAIL mixed_pending_auto: got %h expected 00ff", pending); end
      auto = 1'b0; din = 1'b0;
      for (int s = 8; s <= 14; s++) begin
         S = 4'(s);
         tick();
      end
      checks++; if (slot !== 4'd8) begin errors++; $display("FAIL mixed_slot_hold: got %0d expected 8", slot); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mixed_valid_early: got %b expected 0", out_valid); end
      S = 4'd15;
      tick();
      checks++; if (out !== 16'h00FF) begin errors++; $display("FAIL mixed_out: got %h expected 00ff", out); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mixed_valid: got %b expected 1", out_valid); end
      checks++; if (slot !== 4'd0) begin errors++; $display("FAIL mixed_slot_after: got %0d expected 0", slot); end
      wr_en = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mixed_valid_drop: got %b expected 0", out_valid); end
   endtask

   // Fill 6E19, read each lane back through a 16-to-1 select, then reset
   task automatic test_round_trip();
      logic [15:0] word;
      logic        mux_bit;
      word = 16'h6E19;
      auto = 1'b1; wr_en = 1'b1; clear = 1'b0;
      for (int i = 0; i < 16; i++) begin
         din = word[i];
         tick();
      end
      wr_en = 1'b0;
      checks++; if (out !== 16'h6E19) begin errors++; $display("FAIL rt_out: got %h expected 6e19", out); end
      for (int s = 0; s < 16; s++) begin
         S = 4'(s);
         mux_bit = out[S];
         checks++;
         if (mux_bit !== word[s]) begin
            errors++; $display("FAIL rt_lane_%0d: got %b expected %b", s, mux_bit, word[s]);
         end
      end
      #2 rst = 1'b1;
      #1;
      checks++; if (out !== 16'h0000) begin errors++; $display("FAIL rt_reset_out: got %h expected 0000", out); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rt_reset_valid: got %b expected 0", out_valid); end
      #1 rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_auto_fill();
      test_back_to_back();
      test_addressed_rewrite();
      test_clear_priority();
      test_mixed_mode();
      test_round_trip();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
